// File: rtl/pipeline_reg_chain.sv
// pipeline_reg_chain: elastic valid/ready register chain with stall, per-stage flush and NOP bubbles.
// Optional performance counters (stall_cnt, bubble_cnt) are built when PIPE_PERF_CNT_EN is defined.
module pipeline_reg_chain #(
    parameter int WIDTH = 21,
    parameter int STAGES = 4,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [STAGES-1:0]            flush,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  bubble_cnt
);
    localparam int OW = $clog2(STAGES+1);
    logic [WIDTH-1:0]  data [STAGES];
    logic [WIDTH-1:0]  prev_data [STAGES];
    logic [STAGES-1:0] valid, prev_valid, adv;
    // Walk from the output back so an empty stage anywhere downstream frees the stages above it.
    always_comb begin
        logic a;
        a = out_ready;
        adv = '0;
        for (int i = STAGES-1; i >= 0; i--) begin
            a = a | !valid[i];
            adv[i] = a;
        end
    end
    always_comb begin
        prev_valid = '0;
        for (int i = 0; i < STAGES; i++) prev_data[i] = NOP_VALUE;
        prev_valid[0] = in_valid;
        prev_data[0] = in_valid ? in_data : NOP_VALUE;
        for (int i = 1; i < STAGES; i++) begin
            prev_valid[i] = valid[i-1];
            prev_data[i] = data[i-1];
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (reset || flush[i]) begin
                valid[i] <= 1'b0;
                data[i] <= NOP_VALUE;
            end else if (adv[i]) begin
                valid[i] <= prev_valid[i];
                data[i] <= prev_data[i];
            end
        end
    end
    assign in_ready = adv[0];
    assign out_valid = valid[STAGES-1];
    assign out_data = data[STAGES-1];
    assign occupancy = OW'($countones(valid));
`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_reg_chain.sv
// tb_pipeline_reg_chain: directed vector table plus a reset-while-loaded sequence for pipeline_reg_chain.
module tb_pipeline_reg_chain;
    typedef struct {
        int iv;
        int din;
        int ordy;
        int fl;
        int eir;
        int eov;
        int edo;
        int eocc;
    } vec_t;

    logic        clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic [20:0] in_data, out_data;
    logic [3:0]  flush;
    logic [2:0]  occupancy;
    logic [31:0] stall_cnt, bubble_cnt;
    int checks = 0;
    int fails = 0;
    vec_t q[$];

    pipeline_reg_chain #(.WIDTH(21), .STAGES(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] w(input int n);
        return (n == 0) ? 21'd0 : {n[4:0], 16'hA5C3 ^ n[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int iv, input int din, input int ordy, input int fl);
        in_valid = (iv != 0);
        in_data = (iv != 0) ? w(din) : 21'h1FFFFF;
        out_ready = (ordy != 0);
        flush = 4'(fl);
    endtask

    initial begin
        // iv din ordy flush | in_ready out_valid out_word occupancy
        q.push_back('{1, 1, 1, 0, 1, 0, 0, 1});
        q.push_back('{1, 2, 1, 0, 1, 0, 0, 2});
        q.push_back('{1, 3, 1, 0, 1, 0, 0, 3});
        q.push_back('{1, 4, 1, 0, 1, 1, 1, 4});
        q.push_back('{1, 5, 1, 0, 1, 1, 2, 4});
        q.push_back('{1, 6, 0, 0, 0, 1, 2, 4});
        q.push_back('{1, 6, 0, 0, 0, 1, 2, 4});
        q.push_back('{1, 6, 0, 0, 0, 1, 2, 4});
        q.push_back('{1, 6, 1, 0, 1, 1, 3, 4});
        q.push_back('{1, 7, 1, 3, 1, 1, 4, 2});
        q.push_back('{1, 8, 1, 0, 1, 1, 5, 2});
        q.push_back('{1, 9, 1, 0, 1, 0, 0, 2});
        q.push_back('{0, 0, 1, 0, 1, 0, 0, 2});
        q.push_back('{0, 0, 1, 0, 1, 1, 8, 2});
        q.push_back('{0, 0, 1, 0, 1, 1, 9, 1});
        q.push_back('{0, 0, 1, 0, 1, 0, 0, 0});
        q.push_back('{1, 10, 1, 0, 1, 0, 0, 1});
        q.push_back('{0, 0, 1, 0, 1, 0, 0, 1});
        q.push_back('{0, 0, 1, 0, 1, 0, 0, 1});
        q.push_back('{0, 0, 1, 0, 1, 1, 10, 1});
        q.push_back('{1, 11, 0, 0, 1, 1, 10, 2});
        q.push_back('{1, 12, 0, 0, 1, 1, 10, 3});
        q.push_back('{1, 13, 0, 0, 1, 1, 10, 4});
        q.push_back('{1, 14, 0, 0, 0, 1, 10, 4});
        q.push_back('{1, 14, 0, 8, 0, 0, 0, 3});
        q.push_back('{1, 14, 1, 1, 1, 1, 11, 3});
        q.push_back('{0, 0, 1, 0, 1, 1, 12, 2});
        q.push_back('{0, 0, 1, 0, 1, 1, 13, 1});
        q.push_back('{0, 0, 1, 0, 1, 0, 0, 0});

        reset = 1'b1;
        drive(1, 31, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset occupancy", 32'(occupancy), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset stall_cnt", stall_cnt, 32'd0);

        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            drive(q[k].iv, q[k].din, q[k].ordy, q[k].fl);
            #1 chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(q[k].eir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(q[k].eov));
            chk($sformatf("v%0d out_data", k), 32'(out_data), 32'(w(q[k].edo)));
            chk($sformatf("v%0d occupancy", k), 32'(occupancy), 32'(q[k].eocc));
            if (k == 7) begin
`ifdef PIPE_PERF_CNT_EN
                chk("stall_cnt after 3 stalls", stall_cnt, 32'd3);
`else
                chk("stall_cnt tied off", stall_cnt, 32'd0);
                chk("bubble_cnt tied off", bubble_cnt, 32'd0);
`endif
            end
        end

        // Load three stages, then reset mid-stream with flush and new input also asserted.
        for (int k = 20; k < 23; k++) begin
            @(negedge clk);
            drive(1, k, 1, 0);
        end
        @(negedge clk);
        drive(0, 0, 1, 0);
        #1 chk("preload occupancy", 32'(occupancy), 32'd3);
        reset = 1'b1;
        drive(1, 23, 0, 15);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset out_data", 32'(out_data), 32'd0);
        chk("midreset occupancy", 32'(occupancy), 32'd0);
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        chk("midreset stall_cnt", stall_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
